uart_rx_cfg: RTL and testbench
==============================

# uart_rx_cfg

Parametrised UART receiver for the MIDI input path and the debug serial port, replacing the fixed 8N1 receiver. It oversamples `rxd` on a shared baud-tick enable and uses majority-vote bit sampling with false-start rejection. It implements parity, framing and overrun detection and delivers words through a valid/ready holding register, so consumers can stall without losing a completed frame silently.

## Interface
- `DATA_BITS`, 8, data bits per frame, 5..9, LSB received first
- `OVERSAMPLE`, 16, `bclk_en` ticks per bit, even, 8..32
- `PARITY`, 0, 0 none / 1 even / 2 odd
- `STOP_BITS`, 1, 1 or 2
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high
- `bclk_en`  in  1  one-`clk` pulse per sample tick (OVERSAMPLE × baud)
- `rxd`  in  1  serial input, idle high, asynchronous
- `rx_data`  out  DATA_BITS  received word, valid while `rx_valid`
- `rx_valid`  out  1  holding register full
- `rx_ready`  in  1  consumer accepts word when `rx_valid & rx_ready`
- `frame_err`  out  1  stop bit sampled low; qualified by `rx_valid`
- `parity_err`  out  1  parity mismatch; qualified by `rx_valid`; 0 when PARITY=0
- `overrun`  out  1  one-`clk` pulse: frame completed while register full
- `busy`  out  1  state ≠ IDLE
- `state`  out  3  current FSM state, for debug

## Operation
- `rxd` passes through a 2-flop synchroniser clocked every `clk`, reset to 1. All following logic advances only on `bclk_en`.
- On each tick, a 3-deep sample history shifts in the synchronised bit. The bit value is the majority of the three samples.
- `cnt` (log2 OVERSAMPLE bits) increments per tick and wraps at OVERSAMPLE-1. The sample point is `cnt == OVERSAMPLE/2+1`, so the vote covers ticks OS/2-1..OS/2+1.
- FSM states: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.
  - IDLE: on a tick with previous sample 1 and current sample 0, clear `cnt` and go to START.
  - START: at the sample point, vote 1 means a false start, so return to IDLE with no outputs. Vote 0 goes to DATA with `bitidx=0`.
  - DATA: at each sample point, shift the vote in LSB-first and increment `bitidx`. After DATA_BITS bits, go to PARITY if PARITY≠0, else STOP.
  - PARITY: at the sample point, compute the error flag. Even parity: XOR of data and parity bit must be 0. Odd parity: that XOR must be 1. Then go to STOP.
  - STOP: sample each stop bit at its sample point. Any stop vote of 0 sets `frame_err`. At the last stop bit's sample point, complete the frame and return to IDLE immediately; do not wait for the end of the bit.
- On completion, if the holding register is empty, or is being accepted in that same cycle, load `rx_data`, `frame_err` and `parity_err`, and set `rx_valid`.
- If the register is full and not being accepted, drop the new word, keep the old word unchanged, and pulse `overrun`.
- Words with errors are still delivered, with their flags set.
- A held-low line (break) gives one frame_err word. No further start is detected until the line returns high.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `frame_err`=0, `parity_err`=0, `overrun`=0, `busy`=0, `state`=IDLE, `cnt`=0, and synchroniser/history flops all 1.
- Input latency is 2 `clk` for the synchroniser plus tick alignment.
- `rx_valid` rises on the `clk` after the `bclk_en` tick at the final stop sample point.
- From start edge to `rx_valid` is (1 + DATA_BITS + (PARITY≠0) + STOP_BITS - 1)·OVERSAMPLE + OVERSAMPLE/2+1 ticks, plus 1 clk.
- `rx_valid` stays high until the handshake. It falls on the `clk` after `rx_valid & rx_ready` unless a new word loads in that cycle.
- If completion and handshake coincide, the new word loads, `rx_valid` stays 1, and there is no overrun.
- `reset` mid-frame: the frame is abandoned immediately and no word or flag is produced.
- Back-to-back frames with zero idle time must be received correctly. A start edge is detectable from the first tick after completion.

## Structure
- Package `uart_pkg`: FSM state enum (3-bit) and parity-mode constants (`PAR_NONE`, `PAR_EVEN`, `PAR_ODD`). These are shared with the transmitter.
- Sub-module `uart_rx_sampler`: synchroniser, 3-sample history, majority vote and falling-edge detect. Outputs are `vote`, `fall` and `sample`.
- Top level: FSM, counters, shift register and holding register.

## Test plan
- **Clean frame:** defaults, 0x90 sent at OS=16 → `rx_data`=0x90, `rx_valid` after 9·16+9 ticks, no errors. Then 0x3C, 0x7F back-to-back with zero idle → both received.
- **Glitch rejection:** 4-tick low pulse on idle line → returns to IDLE, no `rx_valid`. Single-tick glitch mid-bit → majority vote gives correct data.
- **Parity:** PARITY=1, 0x55 sent with parity bit 0 → `parity_err`=0. Parity bit 1 → `parity_err`=1, data still 0x55. PARITY=2 gives the inverse results.
- **Framing and break:** stop bit forced low → `frame_err`=1. `rxd` held low for 3 frame times → exactly one word 0x00 with `frame_err`=1.
- **Overrun and handshake:** `rx_ready`=0, two frames 0x11, 0x22 → `rx_data` stays 0x11 and `overrun` pulses once. `rx_ready` asserted on the completion cycle of the second frame → 0x22 loads, `rx_valid` stays 1.
- **Width config:** DATA_BITS=9, STOP_BITS=2, PARITY=2, word 0x1A5 → received correctly. `reset` asserted mid-DATA → `busy`=0 next cycle and no word produced.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, parity modes and a vote helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Two-out-of-three majority used for noise-tolerant bit decisions.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Input conditioning for the UART receiver: 2-flop synchroniser, sample
// history advanced on the baud tick, majority vote and falling-edge detect.
// vote and fall include the sample being taken on the current tick, so at the
// sample point the vote spans that tick and the two before it.
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic bclk_en,
  input  logic rxd,
  output logic vote,
  output logic fall,
  output logic sample
);

  logic [1:0] sync;
  logic [1:0] hist;

  // Synchronise the asynchronous line every clk; idle level is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= 2'b11;
    else       sync <= {sync[0], rxd};
  end

  assign sample = sync[1];

  // Keep the two previous tick samples; together with the live sample they
  // form the three-deep voting window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        hist <= 2'b11;
    else if (bclk_en) hist <= {hist[0], sample};
  end

  assign vote = majority3(hist[1], hist[0], sample);
  assign fall = hist[0] & ~sample;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: oversampled start detection with false-start
// rejection, LSB-first data, optional parity, 1 or 2 stop bits, and a
// single-entry holding register with overrun reporting.
//
// Output handshake: rx_valid stays high while the holding register is full;
// a word is consumed on any clk edge where rx_valid & rx_ready. rx_data,
// frame_err and parity_err are stable while rx_valid is high and only change
// when a new word loads, which happens only if the register is empty or is
// being consumed on that same edge.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bclk_en,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy,
  output logic [2:0]           state
);

  localparam int            CW         = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_LAST   = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_SAMPLE = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [3:0]    LAST_DATA  = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP  = 4'(STOP_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cnt;
  logic [3:0]           bitidx;
  logic [DATA_BITS-1:0] shreg;
  logic                 ferr_acc;
  logic                 perr_acc;
  logic                 vote;
  logic                 fall;
  logic                 line_unused;
  logic                 sample_pt;
  logic                 complete;
  logic                 frame_bad;

  // Raw synchronised level is available for probing; the frame logic uses
  // only the vote and the edge detect.
  uart_rx_sampler u_sampler (
    .clk     (clk),
    .reset   (reset),
    .bclk_en (bclk_en),
    .rxd     (rxd),
    .vote    (vote),
    .fall    (fall),
    .sample  (line_unused)
  );

  assign sample_pt = bclk_en && (cnt == CNT_SAMPLE);
  assign frame_bad = ferr_acc | ~vote;
  assign busy      = (state_q != ST_IDLE);
  assign state     = state_q;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; complete marks the final stop-bit sample point.
  always_comb begin
    state_d  = state_q;
    complete = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bclk_en && fall) state_d = ST_START;
      end
      ST_START: begin
        if (sample_pt) state_d = vote ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (sample_pt && bitidx == LAST_DATA)
          state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (sample_pt) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (sample_pt && bitidx == LAST_STOP) begin
          state_d  = ST_IDLE;
          complete = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Tick counter, bit index, data shifter and error accumulators. The tick on
  // which the falling edge is seen is count 0 of the start bit, so the
  // counter is loaded with 1 for the following tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      bitidx   <= '0;
      shreg    <= '0;
      ferr_acc <= 1'b0;
      perr_acc <= 1'b0;
    end else if (bclk_en) begin
      if (state_q == ST_IDLE) begin
        cnt      <= fall ? CW'(1) : '0;
        bitidx   <= '0;
        ferr_acc <= 1'b0;
        perr_acc <= 1'b0;
      end else begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        if (cnt == CNT_SAMPLE) begin
          case (state_q)
            ST_DATA: begin
              shreg  <= {vote, shreg[DATA_BITS-1:1]};
              bitidx <= (bitidx == LAST_DATA) ? '0 : bitidx + 1'b1;
            end
            ST_PARITY: begin
              perr_acc <= (PARITY == PAR_ODD) ? ~(^shreg ^ vote) : (^shreg ^ vote);
            end
            ST_STOP: begin
              ferr_acc <= ferr_acc | ~vote;
              bitidx   <= bitidx + 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Holding register: load on completion when empty or being drained this
  // edge; otherwise keep the old word and flag the lost frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (complete && (!rx_valid || rx_ready)) begin
        rx_data    <= shreg;
        rx_valid   <= 1'b1;
        frame_err  <= frame_bad;
        parity_err <= perr_acc;
      end else begin
        if (complete)              overrun  <= 1'b1;
        if (rx_valid && rx_ready)  rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three configurations side by side (8N1/OS16,
// 9 bits odd parity 2 stop/OS8, 8 bits even parity 1 stop/OS16). Frames are
// built bit by bit from the frame format, expected words queued per DUT and
// popped by a monitor on every handshake.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

  localparam int TICK_DIV = 3;
  localparam int NDUT     = 3;

  int db_cfg  [NDUT] = '{8, 9, 8};
  int os_cfg  [NDUT] = '{16, 8, 16};
  int par_cfg [NDUT] = '{0, 2, 1};
  int sb_cfg  [NDUT] = '{1, 2, 1};

  logic            clk = 1'b0;
  logic            reset;
  logic            bclk_en;
  logic [NDUT-1:0] rxd_v;
  logic [NDUT-1:0] ready_v;

  wire [7:0]      data_a;
  wire [8:0]      data_b;
  wire [7:0]      data_c;
  wire [2:0]      state_a, state_b, state_c;
  wire [NDUT-1:0] valid_v, ferr_v, perr_v, ovr_v, busy_v;

  logic [10:0] exp_q [NDUT][$];
  int checks = 0;
  int errors = 0;
  int ovr_cnt   [NDUT] = '{0, 0, 0};
  int rise_tick [NDUT] = '{0, 0, 0};
  int tick_cnt = 0;

  uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .reset(reset), .bclk_en(bclk_en), .rxd(rxd_v[0]),
    .rx_data(data_a), .rx_valid(valid_v[0]), .rx_ready(ready_v[0]),
    .frame_err(ferr_v[0]), .parity_err(perr_v[0]), .overrun(ovr_v[0]),
    .busy(busy_v[0]), .state(state_a));

  uart_rx_cfg #(.DATA_BITS(9), .OVERSAMPLE(8), .PARITY(2), .STOP_BITS(2)) u_b (
    .clk(clk), .reset(reset), .bclk_en(bclk_en), .rxd(rxd_v[1]),
    .rx_data(data_b), .rx_valid(valid_v[1]), .rx_ready(ready_v[1]),
    .frame_err(ferr_v[1]), .parity_err(perr_v[1]), .overrun(ovr_v[1]),
    .busy(busy_v[1]), .state(state_b));

  uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(1), .STOP_BITS(1)) u_c (
    .clk(clk), .reset(reset), .bclk_en(bclk_en), .rxd(rxd_v[2]),
    .rx_data(data_c), .rx_valid(valid_v[2]), .rx_ready(ready_v[2]),
    .frame_err(ferr_v[2]), .parity_err(perr_v[2]), .overrun(ovr_v[2]),
    .busy(busy_v[2]), .state(state_c));

  // ---------------- clock / reset / tick ----------------
  initial forever #5 clk = ~clk;

  initial begin
    bclk_en = 1'b0;
    forever begin
      repeat (TICK_DIV - 1) @(negedge clk);
      bclk_en = 1'b1;
      @(negedge clk);
      bclk_en = 1'b0;
    end
  end

  always @(posedge clk) if (bclk_en) tick_cnt <= tick_cnt + 1;

  initial begin
    #900000;
    $display("FAIL watchdog time_limit_reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [8:0] dut_data(input int d);
    case (d)
      0:       return {1'b0, data_a};
      1:       return data_b;
      default: return {1'b0, data_c};
    endcase
  endfunction

  function automatic logic [2:0] dut_state(input int d);
    case (d)
      0:       return state_a;
      1:       return state_b;
      default: return state_c;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Returns #1 after a clk edge on which bclk_en was high.
  task automatic wait_tick();
    do @(posedge clk); while (!bclk_en);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) wait_tick();
  endtask

  // ---------------- driver ----------------
  // Must be entered tick-aligned. Each bit is held for OVERSAMPLE ticks.
  // glitch_bit: index of the bit (0 = start) that gets a one-tick inversion
  // at its centre, -1 for none. pulse_ready raises rx_ready only on the clk
  // edge of the final stop-bit sample point.
  task automatic send_frame(input int d, input logic [8:0] data, input bit bad_par,
                            input bit bad_stop, input int glitch_bit,
                            input bit pulse_ready, input bit push, output int t_start);
    bit         bits[$];
    int         os;
    logic [8:0] w;
    logic       p;
    os = os_cfg[d];
    w  = '0;
    p  = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < db_cfg[d]; i++) begin
      bits.push_back(data[i]);
      w[i] = data[i];
      p    = p ^ data[i];
    end
    if (par_cfg[d] != 0) bits.push_back(((par_cfg[d] == 2) ? ~p : p) ^ bad_par);
    for (int i = 0; i < sb_cfg[d]; i++) bits.push_back(!(bad_stop && i == 0));
    if (push) exp_q[d].push_back({bad_par && (par_cfg[d] != 0), bad_stop, w});
    t_start = tick_cnt;
    for (int i = 0; i < bits.size(); i++) begin
      rxd_v[d] = bits[i];
      if (i == glitch_bit) begin
        wait_ticks(os / 2);
        rxd_v[d] = ~bits[i];
        wait_ticks(1);
        rxd_v[d] = bits[i];
        wait_ticks(os / 2 - 1);
      end else if (pulse_ready && i == bits.size() - 1) begin
        wait_ticks(os / 2 + 1);
        repeat (TICK_DIV - 1) @(posedge clk);
        #1 ready_v[d] = 1'b1;
        @(posedge clk);
        #1 ready_v[d] = 1'b0;
        wait_ticks(os - os / 2 - 2);
      end else begin
        wait_ticks(os);
      end
    end
    rxd_v[d] = 1'b1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic monitor(input int d);
    logic        prev_valid;
    logic [10:0] a;
    logic [10:0] e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (valid_v[d] && !prev_valid) rise_tick[d] = tick_cnt;
      prev_valid = valid_v[d];
      if (ovr_v[d]) ovr_cnt[d]++;
      if (valid_v[d] && ready_v[d]) begin
        a = {perr_v[d], ferr_v[d], dut_data(d)};
        if (exp_q[d].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word dut%0d actual=0x%0h required=none", d, a);
        end else begin
          e = exp_q[d].pop_front();
          check($sformatf("word_dut%0d", d), a, e);
        end
      end
    end
  endtask

  initial begin
    fork
      monitor(0);
      monitor(1);
      monitor(2);
    join_none
  end

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    int ovr0;
    int nb;
    logic [8:0] dat;
    bit bp, bs;
    int gb;

    rxd_v   = '1;
    ready_v = '1;
    reset   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("reset_valid_dut%0d", d), valid_v[d], 0);
      check($sformatf("reset_busy_dut%0d", d), busy_v[d], 0);
      check($sformatf("reset_state_dut%0d", d), dut_state(d), 0);
      check($sformatf("reset_data_dut%0d", d), dut_data(d), 0);
      check($sformatf("reset_flags_dut%0d", d), {ferr_v[d], perr_v[d], ovr_v[d]}, 0);
    end
    reset = 1'b0;
    wait_ticks(4);

    // Clean 8N1 frame; the first low tick is tick 0 and the word is visible
    // after (1+8+0+1-1)*16 + 16/2+1 further ticks.
    send_frame(0, 9'h090, 0, 0, -1, 0, 1, t0);
    check("latency_8n1", rise_tick[0] - t0, 1 + (1 + 8 + 0 + 1 - 1) * 16 + 16 / 2 + 1);
    send_frame(0, 9'h03C, 0, 0, -1, 0, 1, t0);
    send_frame(0, 9'h07F, 0, 0, -1, 0, 1, t0);
    wait_ticks(8);

    // Short low pulse on an idle line is rejected.
    rxd_v[0] = 1'b0;
    wait_ticks(4);
    rxd_v[0] = 1'b1;
    wait_ticks(16);
    check("false_start_busy", busy_v[0], 0);
    check("false_start_valid", valid_v[0], 0);

    // One-tick glitches in the middle of a data bit and of the start bit.
    send_frame(0, 9'h0A5, 0, 0, 3, 0, 1, t0);
    send_frame(0, 9'h05A, 0, 0, 0, 0, 1, t0);

    // Parity: even on dut2, odd on dut1; good then bad parity bit.
    send_frame(2, 9'h055, 0, 0, -1, 0, 1, t0);
    send_frame(2, 9'h055, 1, 0, -1, 0, 1, t0);
    send_frame(1, 9'h055, 0, 0, -1, 0, 1, t0);
    send_frame(1, 9'h055, 1, 0, -1, 0, 1, t0);
    send_frame(1, 9'h1A5, 0, 0, -1, 0, 1, t0);

    // Framing error, then a break of three frame times.
    send_frame(0, 9'h042, 0, 1, -1, 0, 1, t0);
    wait_ticks(16);
    exp_q[0].push_back({1'b0, 1'b1, 9'h000});
    rxd_v[0] = 1'b0;
    wait_ticks(3 * 10 * 16);
    rxd_v[0] = 1'b1;
    wait_ticks(32);
    check("break_idle_busy", busy_v[0], 0);

    // Reset in the middle of the data bits of dut1.
    rxd_v[1] = 1'b0;
    wait_ticks(8 * 4);
    check("mid_frame_state", dut_state(1), 2);
    reset = 1'b1;
    @(negedge clk);
    check("reset_mid_busy", busy_v[1], 0);
    check("reset_mid_valid", valid_v[1], 0);
    rxd_v[1] = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    wait_ticks(8 * 14);
    check("after_reset_busy", busy_v[1], 0);

    // Overrun and completion coinciding with the handshake on dut0.
    ready_v[0] = 1'b0;
    send_frame(0, 9'h011, 0, 0, -1, 0, 1, t0);
    ovr0 = ovr_cnt[0];
    send_frame(0, 9'h022, 0, 0, -1, 0, 0, t0);
    check("overrun_pulses", ovr_cnt[0] - ovr0, 1);
    check("held_data", dut_data(0), 9'h011);
    check("held_valid", valid_v[0], 1);
    send_frame(0, 9'h033, 0, 0, -1, 1, 1, t0);
    check("coincide_valid", valid_v[0], 1);
    check("coincide_data", dut_data(0), 9'h033);
    check("coincide_no_overrun", ovr_cnt[0] - ovr0, 1);
    ready_v[0] = 1'b1;
    wait_ticks(4);

    // Randomised frames on every configuration.
    for (int d = 0; d < NDUT; d++) begin
      nb = 1 + db_cfg[d] + ((par_cfg[d] != 0) ? 1 : 0) + sb_cfg[d];
      for (int k = 0; k < 8; k++) begin
        dat = 9'($urandom_range(0, (1 << db_cfg[d]) - 1));
        bp  = (par_cfg[d] != 0) && ($urandom_range(0, 3) == 0);
        bs  = ($urandom_range(0, 5) == 0);
        gb  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, nb - 1)) : -1;
        send_frame(d, dat, bp, bs, gb, 0, 1, t0);
        if (bs) wait_ticks(os_cfg[d]);
        else if ($urandom_range(0, 1) == 1) wait_ticks($urandom_range(1, os_cfg[d]));
      end
    end

    // Drain and final accounting.
    for (int i = 0; i < 2000; i++) begin
      if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0) break;
      @(posedge clk);
    end
    repeat (4) @(posedge clk);
    for (int d = 0; d < NDUT; d++)
      check($sformatf("queue_empty_dut%0d", d), exp_q[d].size(), 0);
    check("overrun_total_dut0", ovr_cnt[0], 1);
    check("overrun_total_dut1", ovr_cnt[1], 0);
    check("overrun_total_dut2", ovr_cnt[2], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
